// File: rtl/hamming_route_pkg.sv
// hamming_route_pkg
//   Definitions shared by the routing Hamming(7,4) transmitter and receiver:
//   FSM state encoding, frame-length constants, serial line levels and the
//   codeword position map (positions 1..7 = p1 p2 d1 p3 d2 d3 d4).
//   Optional macro: HAMMING_TX_SECDED_EN adds the XPAR state (overall parity bit).
package hamming_route_pkg;

  // Frame lengths in bits: start + 2 destination + 7 codeword (+ parity) + stop
  localparam int FRAME_BITS_BASE   = 11;
  localparam int FRAME_BITS_SECDED = 12;

  localparam int DEST_BITS = 2;
  localparam int CW_BITS   = 7;

  // Serial line levels
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Codeword position map; vectors of type codeword_t are indexed by position
  localparam int CW_POS_P1 = 1;
  localparam int CW_POS_P2 = 2;
  localparam int CW_POS_D1 = 3;
  localparam int CW_POS_P3 = 4;
  localparam int CW_POS_D2 = 5;
  localparam int CW_POS_D3 = 6;
  localparam int CW_POS_D4 = 7;

  typedef logic [7:1] codeword_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DEST,
    ST_CODE,
`ifdef HAMMING_TX_SECDED_EN
    ST_XPAR,
`endif
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/hamming74_enc.sv
// hamming74_enc
//   Purely combinational Hamming(7,4) encoder.
//   Ports:
//     data           in   4  d1=data[3], d2=data[2], d3=data[1], d4=data[0]
//     codeword       out  7  indexed by position 1..7 (p1 p2 d1 p3 d2 d3 d4)
//     overall_parity out  1  XOR of all 7 codeword bits (only with HAMMING_TX_SECDED_EN)
//   Optional macro: HAMMING_TX_SECDED_EN.
module hamming74_enc
  import hamming_route_pkg::*;
(
  input  logic [3:0] data,
  output codeword_t  codeword
`ifdef HAMMING_TX_SECDED_EN
  ,
  output logic       overall_parity
`endif
);

  logic d1, d2, d3, d4;

  assign d1 = data[3];
  assign d2 = data[2];
  assign d3 = data[1];
  assign d4 = data[0];

  always_comb begin
    codeword            = '0;
    codeword[CW_POS_P1] = d1 ^ d2 ^ d4;
    codeword[CW_POS_P2] = d1 ^ d3 ^ d4;
    codeword[CW_POS_D1] = d1;
    codeword[CW_POS_P3] = d2 ^ d3 ^ d4;
    codeword[CW_POS_D2] = d2;
    codeword[CW_POS_D3] = d3;
    codeword[CW_POS_D4] = d4;
  end

`ifdef HAMMING_TX_SECDED_EN
  assign overall_parity = ^codeword;
`endif

endmodule

// File: rtl/hamming_route_tx.sv
// hamming_route_tx
//   Accepts a destination + data nibble over valid/ready, Hamming(7,4)-encodes
//   the nibble and serializes one frame: start, dest[1], dest[0], codeword
//   positions 1..7, (overall parity), stop. Each bit lasts BIT_CYCLES clocks.
//   Parameters:
//     BIT_CYCLES  clock cycles per serial bit, 1..255
//   Ports:
//     clk       in   1  clock, rising edge
//     rst       in   1  synchronous active-high reset
//     in_valid  in   1  source offers in_dest/in_data
//     in_ready  out  1  block can accept a packet this cycle (IDLE only)
//     in_dest   in   2  destination display index
//     in_data   in   4  data nibble
//     tx_line   out  1  serial line, idles high (registered)
//     tx_busy   out  1  frame in progress
//     tx_done   out  1  one-cycle pulse after a frame completes
//   Optional macro: HAMMING_TX_SECDED_EN adds the XPAR state and a 12-bit frame.
module hamming_route_tx
  import hamming_route_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_dest,
  input  logic [3:0] in_data,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [7:0] DIV_LAST  = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] DEST_LAST = 3'(DEST_BITS - 1);
  localparam logic [2:0] CW_LAST   = 3'(CW_BITS - 1);

  tx_state_e  state_reg, state_next;
  logic [7:0] div_reg, div_next;
  logic [2:0] bit_reg, bit_next;
  logic [1:0] dest_reg;
  codeword_t  cw_reg;
  codeword_t  cw_enc;
  logic       line_reg, line_next;
  logic       ready_reg;
  logic       done_reg;
  logic       accept;
  logic       bit_end;

`ifdef HAMMING_TX_SECDED_EN
  logic xpar_enc;
  logic xpar_reg;

  hamming74_enc u_enc (
    .data           (in_data),
    .codeword       (cw_enc),
    .overall_parity (xpar_enc)
  );
`else
  hamming74_enc u_enc (
    .data     (in_data),
    .codeword (cw_enc)
  );
`endif

  assign accept  = in_valid && ready_reg;
  assign bit_end = (div_reg == DIV_LAST);

  always_comb begin
    state_next = state_reg;
    div_next   = bit_end ? 8'd0 : div_reg + 8'd1;
    bit_next   = bit_reg;

    case (state_reg)
      ST_IDLE: begin
        div_next = 8'd0;
        if (accept) state_next = ST_START;
      end
      ST_START: begin
        if (bit_end) state_next = ST_DEST;
      end
      ST_DEST: begin
        if (bit_end) begin
          if (bit_reg == DEST_LAST) state_next = ST_CODE;
          else                      bit_next   = bit_reg + 3'd1;
        end
      end
      ST_CODE: begin
        if (bit_end) begin
          if (bit_reg == CW_LAST) begin
`ifdef HAMMING_TX_SECDED_EN
            state_next = ST_XPAR;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
`ifdef HAMMING_TX_SECDED_EN
      ST_XPAR: begin
        if (bit_end) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Both counters restart at every state change
    if (state_next != state_reg) begin
      div_next = 8'd0;
      bit_next = 3'd0;
    end

    // Line level is computed from the next state so tx_line can be a flop.
    // dest_reg/cw_reg are already loaded by the time DEST/CODE are reached.
    line_next = LINE_IDLE;
    case (state_next)
      ST_IDLE:  line_next = LINE_IDLE;
      ST_START: line_next = LINE_START;
      ST_DEST:  line_next = bit_next[0] ? dest_reg[0] : dest_reg[1];
      ST_CODE:  line_next = cw_reg[bit_next + 3'd1];
`ifdef HAMMING_TX_SECDED_EN
      ST_XPAR:  line_next = xpar_reg;
`endif
      ST_STOP:  line_next = LINE_STOP;
      default:  line_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      div_reg   <= 8'd0;
      bit_reg   <= 3'd0;
      line_reg  <= LINE_IDLE;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      dest_reg  <= 2'd0;
      cw_reg    <= '0;
`ifdef HAMMING_TX_SECDED_EN
      xpar_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      line_reg  <= line_next;
      ready_reg <= (state_next == ST_IDLE);
      done_reg  <= (state_reg == ST_STOP) && bit_end;
      if (accept) begin
        dest_reg <= in_dest;
        cw_reg   <= cw_enc;
`ifdef HAMMING_TX_SECDED_EN
        xpar_reg <= xpar_enc;
`endif
      end
    end
  end

  assign in_ready = ready_reg;
  assign tx_line  = line_reg;
  assign tx_busy  = (state_reg != ST_IDLE);
  assign tx_done  = done_reg;

endmodule

// File: tb/tb_hamming_route_tx.sv
// tb_hamming_route_tx
//   Directed bench for hamming_route_tx with BIT_CYCLES=4 (dut) and
//   BIT_CYCLES=1 (dut1). Expected frames are hand-encoded 12-bit constants
//   laid out {start, dest1, dest0, cw1..cw7, xpar, stop}; the xpar bit is
//   skipped unless HAMMING_TX_SECDED_EN is defined.
module tb_hamming_route_tx;

  localparam int BC = 4;
`ifdef HAMMING_TX_SECDED_EN
  localparam bit SECDED = 1'b1;
`else
  localparam bit SECDED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_valid1;
  logic [1:0] in_dest;
  logic [3:0] in_data;
  logic       in_ready, tx_line, tx_busy, tx_done;
  logic       in_ready1, tx_line1, tx_busy1, tx_done1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_route_tx #(.BIT_CYCLES(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .tx_line  (tx_line),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  hamming_route_tx #(.BIT_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .tx_line  (tx_line1),
    .tx_busy  (tx_busy1),
    .tx_done  (tx_done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one packet to dut and checks every cycle of its frame. Returns in
  // the tx_done cycle. With keep=1, in_valid stays high and the next packet's
  // fields are driven right after acceptance.
  task automatic send_frame(input logic [1:0] dest, input logic [3:0] data,
                            input logic [11:0] f, input bit keep,
                            input logic [1:0] nxt_dest, input logic [3:0] nxt_data,
                            input string tag);
    int bits_seen = 0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1;
    in_dest  = dest;
    in_data  = data;
    tick();
    if (keep) begin
      in_dest = nxt_dest;
      in_data = nxt_data;
    end else begin
      in_valid = 1'b0;
    end
    for (int b = 11; b >= 0; b--) begin
      if (b == 1 && !SECDED) continue;
      for (int c = 0; c < BC; c++) begin
        n_vec++;
        if (tx_line !== f[b]) begin
          n_err++;
          $display("FAIL %s line bit%0d cyc%0d: got %b want %b", tag, bits_seen, c, tx_line, f[b]);
        end
        n_vec++;
        if (tx_busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy bit%0d cyc%0d: got %b want 1", tag, bits_seen, c, tx_busy);
        end
        n_vec++;
        if (tx_done !== 1'b0 || in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s done/ready bit%0d cyc%0d: got %b/%b want 0/0", tag, bits_seen, c, tx_done, in_ready);
        end
        // Mid-frame input activity that must not disturb the frame
        if (!keep && bits_seen == 3 && c == 0) begin
          in_valid = 1'b1;
          in_dest  = ~dest;
          in_data  = ~data;
        end
        if (!keep && bits_seen == 4 && c == 0) in_valid = 1'b0;
        tick();
      end
      bits_seen++;
    end
    n_vec++;
    if (tx_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_pulse: got %b want 1", tag, tx_done);
    end
    n_vec++;
    if (in_ready !== 1'b1 || tx_busy !== 1'b0 || tx_line !== 1'b1) begin
      n_err++;
      $display("FAIL %s end_state ready/busy/line: got %b/%b/%b want 1/0/1", tag, in_ready, tx_busy, tx_line);
    end
    $display("frame %s dest=%b data=%b bits=%0d", tag, dest, data, bits_seen);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    in_dest   = 2'b00;
    in_data   = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset cyc%0d line/busy/done/ready: got %b/%b/%b/%b want 1/0/0/0",
                 i, tx_line, tx_busy, tx_done, in_ready);
      end
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release ready/line/busy/done: got %b/%b/%b/%b want 1/1/0/0",
               in_ready, tx_line, tx_busy, tx_done);
    end
    $display("reset sequence done");
  endtask

  task automatic test_single();
    // dest=10, data=1011 -> codeword 0110011, overall parity 0
    send_frame(2'b10, 4'b1011, 12'b0_10_0110011_0_1, 1'b0, 2'b00, 4'b0000, "single");
    tick();
    n_vec++;
    if (tx_done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_after done/ready: got %b/%b want 0/1", tx_done, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    // 0000 -> 0000000 parity 0; 1111 -> 1111111 parity 1
    send_frame(2'b00, 4'b0000, 12'b0_00_0000000_0_1, 1'b1, 2'b11, 4'b1111, "b2b_first");
    send_frame(2'b11, 4'b1111, 12'b0_11_1111111_1_1, 1'b0, 2'b00, 4'b0000, "b2b_second");
    tick();
    n_vec++;
    if (tx_done !== 1'b0 || tx_line !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_after done/line: got %b/%b want 0/1", tx_done, tx_line);
    end
  endtask

  task automatic test_reset_mid_frame();
    in_valid = 1'b1;
    in_dest  = 2'b00;
    in_data  = 4'b0000;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    n_vec++;
    if (tx_line !== 1'b0 || tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_before line/busy: got %b/%b want 0/1", tx_line, tx_busy);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_abort line/busy/done/ready: got %b/%b/%b/%b want 1/0/0/0",
               tx_line, tx_busy, tx_done, in_ready);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 50; i++) begin
      n_vec++;
      if (tx_done !== 1'b0 || tx_line !== 1'b1 || tx_busy !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_quiet cyc%0d done/line/busy: got %b/%b/%b want 0/1/0",
                 i, tx_done, tx_line, tx_busy);
      end
      tick();
    end
    $display("mid-frame reset done");
    // dest=01, data=0101 -> codeword 0100101, overall parity 1
    send_frame(2'b01, 4'b0101, 12'b0_01_0100101_1_1, 1'b0, 2'b00, 4'b0000, "after_reset");
    tick();
  endtask

  task automatic test_bit_cycles_one();
    logic [11:0] f;
    int          nb;
    f  = 12'b0_10_0110011_0_1;
    nb = 0;
    n_vec++;
    if (in_ready1 !== 1'b1) begin
      n_err++;
      $display("FAIL bc1_ready: got %b want 1", in_ready1);
    end
    in_valid1 = 1'b1;
    in_dest   = 2'b10;
    in_data   = 4'b1011;
    tick();
    in_valid1 = 1'b0;
    for (int b = 11; b >= 0; b--) begin
      if (b == 1 && !SECDED) continue;
      n_vec++;
      if (tx_line1 !== f[b] || tx_busy1 !== 1'b1 || tx_done1 !== 1'b0) begin
        n_err++;
        $display("FAIL bc1_bit%0d line/busy/done: got %b/%b/%b want %b/1/0",
                 nb, tx_line1, tx_busy1, tx_done1, f[b]);
      end
      nb++;
      tick();
    end
    n_vec++;
    if (tx_done1 !== 1'b1 || in_ready1 !== 1'b1 || tx_line1 !== 1'b1) begin
      n_err++;
      $display("FAIL bc1_done done/ready/line: got %b/%b/%b want 1/1/1", tx_done1, in_ready1, tx_line1);
    end
    tick();
    n_vec++;
    if (tx_done1 !== 1'b0) begin
      n_err++;
      $display("FAIL bc1_done_width: got %b want 0", tx_done1);
    end
    $display("frame bc1 dest=10 data=1011 bits=%0d", nb);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_bit_cycles_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_route_tx.md
# hamming_route_tx

- Transmit-side counterpart of the routing error-correction receiver.
- Accepts a 4-bit data nibble and a 2-bit destination over a valid/ready handshake, and Hamming(7,4)-encodes the nibble.
- Serializes one framed packet per nibble on a single line: start, destination, codeword, stop.
- Sits between the data source and the serial link feeding the receiver/display router.

## Interface
- BIT_CYCLES, 4, clock cycles per serial bit; legal range 1..255.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  source offers in_dest/in_data.
- in_ready  output  1  block can accept a packet this cycle.
- in_dest  input  2  destination display index 0..3.
- in_data  input  4  data nibble; d1=in_data[3], d2=[2], d3=[1], d4=[0].
- tx_line  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress, START through STOP.
- tx_done  output  1  one-cycle pulse after a frame completes.

## Operation
- Codeword, positions 1..7, is p1 p2 d1 p3 d2 d3 d4:
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
- Frame bit order, first to last:
  - start (0)
  - in_dest[1], in_dest[0]
  - codeword positions 1..7
  - stop (1)
- Base frame length is 11 bits.
- in_dest and the codeword are latched at acceptance. Later input changes do not affect the frame in flight.
- FSM states: IDLE, START, DEST, CODE, STOP.
  - IDLE → START on accept (in_valid && in_ready).
  - START → DEST after BIT_CYCLES cycles.
  - DEST → CODE after 2 bits.
  - CODE → STOP after 7 bits (or → XPAR, see Configuration).
  - STOP → IDLE after BIT_CYCLES cycles.
- Counters:
  - Divider counter counts 0..BIT_CYCLES-1.
  - Bit index counter runs within DEST and CODE.
  - Both clear on every state change.
- in_ready = 1 only in IDLE and not in reset. in_valid is ignored outside IDLE; it is neither accepted nor queued.
- tx_busy = 1 in every state except IDLE.

## Timing
- Reset value of every output, applied the cycle after rst is sampled high:
  - tx_line = 1
  - tx_busy = 0
  - tx_done = 0
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst is sampled low.
- Reset mid-frame aborts the frame:
  - Line returns high next cycle.
  - No tx_done pulse.
  - The latched packet is discarded.
- Accept at edge k: tx_line = 0 for cycles k+1 .. k+BIT_CYCLES. Each later bit holds for exactly BIT_CYCLES cycles.
- Stop bit's final cycle is cycle k + 11·BIT_CYCLES. On the next edge:
  - FSM enters IDLE.
  - tx_done = 1 for exactly one cycle.
  - in_ready = 1 in that same cycle.
- Back-to-back packets: with in_valid held high, the next accept occurs in the tx_done cycle. Minimum spacing is (11·BIT_CYCLES + 1) cycles per packet, with one idle-high cycle between frames.
- BIT_CYCLES = 1: each bit lasts one cycle; no other behaviour changes.
- Encoding is combinational into the latch; no extra latency cycles.

## Configuration
- HAMMING_TX_SECDED_EN defined:
  - Adds state XPAR between CODE and STOP.
  - XPAR transmits one overall even-parity bit (XOR of the 7 codeword bits).
  - Frame is 12 bits; minimum packet spacing is 12·BIT_CYCLES + 1 cycles.
- Undefined: no XPAR state; 11-bit frame as above.

## Structure
- Shared package `hamming_route_pkg` holds:
  - FSM state enum
  - frame-length constants (FRAME_BITS_BASE=11, FRAME_BITS_SECDED=12)
  - start/stop/idle line levels
  - codeword position map
- The receiver uses the same package.
- One sub-module: `hamming74_enc`. Purely combinational, 4-bit in, 7-bit codeword out (plus overall parity under the macro). Reusable by verification as the reference encoder.

## Test plan
- BIT_CYCLES=4, rst held 3 cycles then released → tx_line=1, tx_busy=0, tx_done=0 throughout; in_ready=0 during reset, 1 the cycle after release.
- Accept dest=2'b10, data=4'b1011 → line sequence 0,1,0,0,1,1,0,0,1,1,1, each held 4 cycles. tx_done pulses at accept+45. Codeword 0110011.
- dest=2'b00, data=4'b0000, then dest=2'b11, data=4'b1111 with in_valid held → frames 0,0,0,0000000,1 and 0,1,1,1111111,1. Second accept occurs in the tx_done cycle of the first. in_valid changes mid-frame have no effect.
- rst asserted on cycle 20 of a frame → line high next cycle, tx_busy=0, no tx_done; a new packet afterwards transmits cleanly.
- BIT_CYCLES=1 with data=4'b1011 → 11-cycle frame, tx_done at accept+12.
- HAMMING_TX_SECDED_EN, data=4'b1111 → XPAR bit = 1, 12-bit frame. data=4'b1011 → XPAR bit = 0.
